// File: rtl/rstc_seq.sv
// Reset sequencer: merges filtered, maskable reset requests into
// stretched, staggered active-low domain resets with a sticky cause log.
module rstc_seq #(
   parameter int                 NUM_SRC   = 4,
   parameter logic [NUM_SRC-1:0] FILT_MASK = 4'b0001,
   parameter int                 FILT_W    = 8,
   parameter int                 HOLD_CYC  = 16,
   parameter int                 NUM_OUT   = 3,
   parameter int                 STAGE_GAP = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] src_req,
   input  logic [NUM_SRC-1:0] src_en,
   input  logic               cause_clr,
   output logic [NUM_OUT-1:0] rst_n_out,
   output logic [NUM_SRC-1:0] cause,
   output logic               busy
);

   localparam int HW = $clog2(HOLD_CYC);
   localparam int GW = $clog2(STAGE_GAP) + 1;
   localparam int SW = $clog2(NUM_OUT) + 1;

   localparam logic [HW-1:0] H_END = HW'(HOLD_CYC - 1);
   localparam logic [GW-1:0] G_END = GW'(STAGE_GAP - 1);
   localparam logic [SW-1:0] S_END = SW'(NUM_OUT - 1);

   typedef enum logic [1:0] {
      HOLD,
      RELEASE,
      RUN
   } state_t;

   state_t state, state_nxt;

   logic [HW-1:0]      hcnt, hcnt_nxt;
   logic [GW-1:0]      gcnt, gcnt_nxt;
   logic [SW-1:0]      stg, stg_nxt;
   logic [NUM_SRC-1:0] s1, s2, qual;
   logic [NUM_OUT-1:0] rst_n_nxt;
   logic               busy_nxt;
   logic               evt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= src_req;
         s2 <= s1;
      end
   end

   // Filtered sources qualify only after a saturated run of high samples
   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      if (FILT_MASK[i]) begin : g_filt
         logic [FILT_W-1:0] fcnt;

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               fcnt <= '0;
            else if (!s2[i])
               fcnt <= '0;
            else if (fcnt != '1)
               fcnt <= fcnt + 1'b1;
         end

         assign qual[i] = s2[i] & (&fcnt);
      end else begin : g_raw
         assign qual[i] = s2[i];
      end
   end

   assign evt = |(qual & src_en);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= HOLD;
         hcnt      <= '0;
         gcnt      <= '0;
         stg       <= '0;
         rst_n_out <= '0;
         busy      <= 1'b1;
         cause     <= '0;
      end else begin
         state     <= state_nxt;
         hcnt      <= hcnt_nxt;
         gcnt      <= gcnt_nxt;
         stg       <= stg_nxt;
         rst_n_out <= rst_n_nxt;
         busy      <= busy_nxt;
         cause     <= (cause_clr ? '0 : cause) | (qual & src_en);
      end
   end

   always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      gcnt_nxt  = gcnt;
      stg_nxt   = stg;
      unique case (state)
         HOLD: begin
            if (evt) begin
               hcnt_nxt = '0;
            end else if (hcnt == H_END) begin
               hcnt_nxt = '0;
               gcnt_nxt = '0;
               if (NUM_OUT == 1) begin
                  state_nxt = RUN;
               end else begin
                  state_nxt = RELEASE;
                  stg_nxt   = SW'(1);
               end
            end else begin
               hcnt_nxt = hcnt + 1'b1;
            end
         end
         RELEASE: begin
            if (evt) begin
               state_nxt = HOLD;
               hcnt_nxt  = '0;
               gcnt_nxt  = '0;
               stg_nxt   = '0;
            end else if (gcnt == G_END) begin
               gcnt_nxt = '0;
               stg_nxt  = stg + 1'b1;
               if (stg == S_END)
                  state_nxt = RUN;
            end else begin
               gcnt_nxt = gcnt + 1'b1;
            end
         end
         RUN: begin
            if (evt) begin
               state_nxt = HOLD;
               hcnt_nxt  = '0;
               gcnt_nxt  = '0;
               stg_nxt   = '0;
            end
         end
         default: begin
            state_nxt = HOLD;
            hcnt_nxt  = '0;
            gcnt_nxt  = '0;
            stg_nxt   = '0;
         end
      endcase
   end

   // Outputs decode the next state so the reset pins come straight from flops
   always_comb begin
      busy_nxt  = (state_nxt != RUN);
      rst_n_nxt = '0;
      for (int j = 0; j < NUM_OUT; j++) begin
         rst_n_nxt[j] = (state_nxt == RUN) ||
                        ((state_nxt == RELEASE) && (SW'(j) < stg_nxt));
      end
   end

endmodule

// File: tb/tb_rstc_seq.sv
// Bench for rstc_seq: timing model driven by edges-since-last-event,
// plus directed vectors with literal expectations.
module tb_rstc_seq;

   localparam int NS   = 4;
   localparam int NO   = 3;
   localparam int HOLD = 16;
   localparam int GAP  = 4;
   localparam int FW   = 8;
   localparam logic [NS-1:0] FMASK = 4'b0001;

   logic          clk = 1'b0;
   logic          rst;
   logic [NS-1:0] src_req;
   logic [NS-1:0] src_en;
   logic          cause_clr;
   logic [NO-1:0] rst_n_out;
   logic [NS-1:0] cause;
   logic          busy;

   int tests = 0;
   int fails = 0;

   rstc_seq dut (
      .clk       (clk),
      .rst       (rst),
      .src_req   (src_req),
      .src_en    (src_en),
      .cause_clr (cause_clr),
      .rst_n_out (rst_n_out),
      .cause     (cause),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: run lengths of sampled requests, delayed two edges,
   // and edge count since the last qualifying event.
   int            run1 [NS];
   int            run2 [NS];
   int            since = 0;
   logic [NS-1:0] m_cause = '0;

   initial begin
      for (int i = 0; i < NS; i++) begin
         run1[i] = 0;
         run2[i] = 0;
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         since   = 0;
         m_cause = '0;
         for (int i = 0; i < NS; i++) begin
            run1[i] = 0;
            run2[i] = 0;
         end
      end else begin
         logic [NS-1:0] q;
         q = '0;
         for (int i = 0; i < NS; i++)
            q[i] = run2[i] >= (FMASK[i] ? (1 << FW) : 1);
         m_cause = (cause_clr ? '0 : m_cause) | (q & src_en);
         if (|(q & src_en))
            since = 0;
         else if (since < 100000)
            since = since + 1;
         for (int i = 0; i < NS; i++) begin
            run2[i] = run1[i];
            if (!src_req[i])
               run1[i] = 0;
            else if (run1[i] < 100000)
               run1[i] = run1[i] + 1;
         end
      end
   end

   function automatic logic [NO-1:0] exp_out();
      logic [NO-1:0] v;
      for (int j = 0; j < NO; j++)
         v[j] = since >= HOLD + j * GAP;
      return v;
   endfunction

   always @(negedge clk) begin
      chk("mdl_rst_n", 32'(rst_n_out), 32'(exp_out()));
      chk("mdl_busy", 32'(busy), 32'(since < HOLD + (NO - 1) * GAP));
      chk("mdl_cause", 32'(cause), 32'(m_cause));
   end

   task automatic go(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      src_req   = '0;
      src_en    = '1;
      cause_clr = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;

      // power-on release 16/20/24
      go(15);
      chk("po_e15", 32'(rst_n_out), 32'b000);
      go(1);
      chk("po_e16", 32'(rst_n_out), 32'b001);
      go(4);
      chk("po_e20", 32'(rst_n_out), 32'b011);
      go(3);
      chk("po_e23_busy", 32'(busy), 32'd1);
      go(1);
      chk("po_e24", 32'(rst_n_out), 32'b111);
      chk("po_e24_busy", 32'(busy), 32'd0);
      chk("po_cause", 32'(cause), 32'h0);

      // unfiltered one-cycle pulse on source 1
      go(5);
      src_req[1] = 1'b1;
      go(1);
      src_req[1] = 1'b0;
      go(1);
      chk("unf_k1", 32'(rst_n_out), 32'b111);
      go(1);
      chk("unf_k2", 32'(rst_n_out), 32'b000);
      chk("unf_cause", 32'(cause), 32'b0010);
      go(15);
      chk("unf_c15", 32'(rst_n_out), 32'b000);
      go(1);
      chk("unf_c16", 32'(rst_n_out), 32'b001);
      go(8);
      chk("unf_c24", 32'(rst_n_out), 32'b111);

      // filtered source: short pulse ignored, long hold qualifies
      src_req[0] = 1'b1;
      go(100);
      src_req[0] = 1'b0;
      chk("filt_short", 32'(rst_n_out), 32'b111);
      chk("filt_short_c", 32'(cause), 32'b0010);
      go(5);
      src_req[0] = 1'b1;
      go(257);
      chk("filt_k256", 32'(rst_n_out), 32'b111);
      go(1);
      chk("filt_k257", 32'(rst_n_out), 32'b000);
      chk("filt_cause", 32'(cause), 32'b0011);
      go(10);
      src_req[0] = 1'b0;
      go(40);
      chk("filt_rel", 32'(rst_n_out), 32'b111);

      // masked source
      src_en     = 4'b1011;
      src_req[2] = 1'b1;
      go(50);
      chk("mask_out", 32'(rst_n_out), 32'b111);
      chk("mask_cause", 32'(cause), 32'b0011);
      src_req[2] = 1'b0;
      go(3);
      src_en = '1;
      go(2);

      // clear collides with a new cause bit
      src_req[3] = 1'b1;
      go(1);
      src_req[3] = 1'b0;
      go(1);
      cause_clr = 1'b1;
      go(1);
      cause_clr = 1'b0;
      chk("clr_cause", 32'(cause), 32'b1000);
      chk("clr_out", 32'(rst_n_out), 32'b000);
      go(30);
      chk("clr_rel", 32'(rst_n_out), 32'b111);

      // event while releasing
      src_req[1] = 1'b1;
      go(1);
      src_req[1] = 1'b0;
      go(2);
      chk("mid_k2", 32'(rst_n_out), 32'b000);
      go(16);
      chk("mid_first", 32'(rst_n_out), 32'b001);
      src_req[3] = 1'b1;
      go(1);
      src_req[3] = 1'b0;
      go(1);
      chk("mid_pre", 32'(rst_n_out), 32'b001);
      go(1);
      chk("mid_hit", 32'(rst_n_out), 32'b000);
      chk("mid_busy", 32'(busy), 32'd1);
      go(15);
      chk("mid_c15", 32'(rst_n_out), 32'b000);
      go(1);
      chk("mid_c16", 32'(rst_n_out), 32'b001);
      go(4);
      chk("mid_c20", 32'(rst_n_out), 32'b011);
      go(4);
      chk("mid_c24", 32'(rst_n_out), 32'b111);
      chk("mid_busy0", 32'(busy), 32'd0);
      chk("mid_cause", 32'(cause), 32'b1010);

      // dropping the enable ends an ongoing event
      src_req[1] = 1'b1;
      go(5);
      src_en = 4'b1101;
      go(30);
      chk("en_drop", 32'(rst_n_out), 32'b111);
      src_req[1] = 1'b0;
      go(3);
      src_en = '1;
      go(3);

      // asynchronous reset mid-cycle
      #2 rst = 1'b1;
      #1;
      chk("arst_out", 32'(rst_n_out), 32'b000);
      chk("arst_busy", 32'(busy), 32'd1);
      chk("arst_cause", 32'(cause), 32'h0);
      go(2);
      rst = 1'b0;
      go(24);
      chk("arst_rel", 32'(rst_n_out), 32'b111);
      go(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
